// File: rtl/mem_trace_pkg.sv
// Shared types and widths for memory-trace record transport between taps and the logger.
package mem_trace_pkg;

    localparam int SOURCEID_W = 32;
    localparam int ADDR_W     = 64;
    localparam int DATA_W     = 64;
    localparam int LOGSIZE_W  = 8;
    localparam int CYCLE_W    = 64;
    localparam int REQ_ID_W   = 8;  // covers up to 256 requesters; narrowed at the ports

    typedef struct packed {
        logic [SOURCEID_W-1:0] source;
        logic [ADDR_W-1:0]     address;
        logic                  is_store;
        logic [LOGSIZE_W-1:0]  size;
        logic [DATA_W-1:0]     data;
    } mem_trace_rec_t;

    typedef struct packed {
        logic [REQ_ID_W-1:0] req_id;
        logic [CYCLE_W-1:0]  cycle;
        mem_trace_rec_t      rec;
    } mem_trace_stamped_t;

    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first request at or above ptr.
module rr_arbiter
    import mem_trace_pkg::*;
#(
    parameter int  N     = 4,
    localparam int PTR_W = clog2_min1(N)
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant
);

    int   idx;
    logic found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_trace_log_arbiter.sv
// Round-robin funnel of per-lane trace records into a cycle-stamped FIFO feeding one logger port.
module mem_trace_log_arbiter
    import mem_trace_pkg::*;
#(
    parameter int  NUM_REQ = 4,
    parameter int  DEPTH   = 8,
    localparam int ID_W    = clog2_min1(NUM_REQ),
    localparam int AW      = $clog2(DEPTH),
    localparam int CNT_W   = AW + 1
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [NUM_REQ-1:0]              req_valid,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic [SOURCEID_W*NUM_REQ-1:0]   req_source,
    input  logic [ADDR_W*NUM_REQ-1:0]       req_address,
    input  logic [NUM_REQ-1:0]              req_is_store,
    input  logic [LOGSIZE_W*NUM_REQ-1:0]    req_size,
    input  logic [DATA_W*NUM_REQ-1:0]       req_data,
    output logic                            log_valid,
    input  logic                            log_ready,
    output logic [ID_W-1:0]                 log_req_id,
    output logic [CYCLE_W-1:0]              log_cycle,
    output logic [SOURCEID_W-1:0]           log_source,
    output logic [ADDR_W-1:0]               log_address,
    output logic                            log_is_store,
    output logic [LOGSIZE_W-1:0]            log_size,
    output logic [DATA_W-1:0]               log_data,
    output logic [CNT_W-1:0]                log_count
);

    logic [CYCLE_W-1:0]  cycle_cnt;
    logic [ID_W-1:0]     rr_ptr;
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic [CNT_W-1:0]    count;
    mem_trace_stamped_t  mem [DEPTH];

    logic [NUM_REQ-1:0]  grant;
    logic [ID_W-1:0]     grant_idx;
    logic                space;
    logic                push;
    logic                pop;
    mem_trace_rec_t      sel_rec;
    mem_trace_stamped_t  push_entry;
    mem_trace_stamped_t  head;
    logic                unused_id_bits;

    function automatic logic [ID_W-1:0] onehot_index(input logic [NUM_REQ-1:0] oh);
        logic [ID_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (oh[i]) idx = idx | ID_W'(i);
        end
        return idx;
    endfunction

    function automatic logic [ID_W-1:0] next_ptr(input logic [ID_W-1:0] idx);
        return (int'(idx) + 1 >= NUM_REQ) ? '0 : idx + ID_W'(1);
    endfunction

    rr_arbiter #(.N(NUM_REQ)) u_rr_arbiter (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (grant)
    );

    // Handshakes are masked during reset so nothing enters or leaves in the reset cycle.
    assign log_valid = (count != '0) && !reset;
    assign pop       = log_valid && log_ready;
    assign space     = (count < CNT_W'(DEPTH)) || pop;
    assign req_ready = grant & {NUM_REQ{space && !reset}};
    assign push      = |(req_valid & req_ready);
    assign grant_idx = onehot_index(grant);

    always_comb begin
        sel_rec = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_rec.source   = req_source[i*SOURCEID_W +: SOURCEID_W];
                sel_rec.address  = req_address[i*ADDR_W +: ADDR_W];
                sel_rec.is_store = req_is_store[i];
                sel_rec.size     = req_size[i*LOGSIZE_W +: LOGSIZE_W];
                sel_rec.data     = req_data[i*DATA_W +: DATA_W];
            end
        end
        push_entry.req_id = REQ_ID_W'(grant_idx);
        push_entry.cycle  = cycle_cnt;
        push_entry.rec    = sel_rec;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cycle_cnt <= '0;
            rr_ptr    <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + CYCLE_W'(1);
            if (push) begin
                rr_ptr <= next_ptr(grant_idx);
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; stale entries are unreachable once the pointers clear.
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= push_entry;
    end

    assign head           = mem[rd_ptr];
    assign log_req_id     = head.req_id[ID_W-1:0];
    assign log_cycle      = head.cycle;
    assign log_source     = head.rec.source;
    assign log_address    = head.rec.address;
    assign log_is_store   = head.rec.is_store;
    assign log_size       = head.rec.size;
    assign log_data       = head.rec.data;
    assign log_count      = count;
    assign unused_id_bits = ^head.req_id;

`ifndef SYNTHESIS
    a_count_bound: assert property (@(posedge clock) disable iff (reset) count <= CNT_W'(DEPTH));
    a_ready_onehot: assert property (@(posedge clock) $onehot0(req_ready));
    a_no_empty_pop: assert property (@(posedge clock) disable iff (reset) pop |-> (count != '0));
`endif

endmodule

// File: tb/tb_mem_trace_log_arbiter.sv
// Directed bench for mem_trace_log_arbiter (NUM_REQ=4, DEPTH=8) with hand-computed expectations.
module tb_mem_trace_log_arbiter;

    localparam int NR = 4;
    localparam int DP = 8;

    logic              clock;
    logic              reset;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [32*NR-1:0]  req_source;
    logic [64*NR-1:0]  req_address;
    logic [NR-1:0]     req_is_store;
    logic [8*NR-1:0]   req_size;
    logic [64*NR-1:0]  req_data;
    logic              log_valid;
    logic              log_ready;
    logic [1:0]        log_req_id;
    logic [63:0]       log_cycle;
    logic [31:0]       log_source;
    logic [63:0]       log_address;
    logic              log_is_store;
    logic [7:0]        log_size;
    logic [63:0]       log_data;
    logic [3:0]        log_count;

    int n_checks = 0;
    int n_errors = 0;

    mem_trace_log_arbiter #(.NUM_REQ(NR), .DEPTH(DP)) dut (
        .clock        (clock),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_source   (req_source),
        .req_address  (req_address),
        .req_is_store (req_is_store),
        .req_size     (req_size),
        .req_data     (req_data),
        .log_valid    (log_valid),
        .log_ready    (log_ready),
        .log_req_id   (log_req_id),
        .log_cycle    (log_cycle),
        .log_source   (log_source),
        .log_address  (log_address),
        .log_is_store (log_is_store),
        .log_size     (log_size),
        .log_data     (log_data),
        .log_count    (log_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        req_valid = '0;
        log_ready = 1'b0;
        next_cycle();
        reset = 1'b0;
    endtask

    function automatic logic [63:0] onehot(input int i);
        logic [63:0] v;
        v = 64'd1 << i;
        return v;
    endfunction

    initial begin
        reset     = 1'b1;
        req_valid = '0;
        log_ready = 1'b0;
        for (int i = 0; i < NR; i++) begin
            req_source[i*32 +: 32]  = 32'h5000_0000 + 32'(i);
            req_address[i*64 +: 64] = 64'h8000_0000_0000_0000 + 64'(i) * 64'h40;
            req_is_store[i]         = i[0];
            req_size[i*8 +: 8]      = 8'(i);
            req_data[i*64 +: 64]    = 64'hDA7A_0000_0000_0000 | 64'(i);
        end

        // reset state
        repeat (3) next_cycle();
        check_val("rst_log_valid", 64'(log_valid), 64'd0);
        check_val("rst_log_count", 64'(log_count), 64'd0);
        req_valid = '1;
        #1;
        check_val("rst_req_ready", 64'(req_ready), 64'd0);
        req_valid = '0;
        reset = 1'b0;

        // single requester, first-word latency and cycle stamp
        log_ready = 1'b1;
        repeat (5) next_cycle();
        req_valid = 4'b0001;
        #1;
        check_val("single_ready", 64'(req_ready), 64'd1);
        next_cycle();
        req_valid = '0;
        check_val("single_valid", 64'(log_valid), 64'd1);
        check_val("single_cycle", log_cycle, 64'd5);
        check_val("single_id", 64'(log_req_id), 64'd0);
        check_val("single_source", 64'(log_source), 64'h5000_0000);
        check_val("single_count", 64'(log_count), 64'd1);
        next_cycle();
        check_val("single_drop", 64'(log_valid), 64'd0);

        // all requesters, log_ready high: rotating grants, occupancy 1
        do_reset();
        log_ready = 1'b1;
        req_valid = '1;
        for (int k = 0; k < 8; k++) begin
            #1;
            check_val("rr_ready", 64'(req_ready), onehot(k % 4));
            if (k > 0) begin
                check_val("rr_head_id", 64'(log_req_id), 64'(k - 1) % 64'd4);
                check_val("rr_head_cycle", log_cycle, 64'(k - 1));
                check_val("rr_count", 64'(log_count), 64'd1);
            end
            next_cycle();
        end
        req_valid = '0;
        #1;
        check_val("rr_tail_id", 64'(log_req_id), 64'd3);
        check_val("rr_tail_addr", log_address, 64'h8000_0000_0000_00C0);
        next_cycle();
        check_val("rr_empty", 64'(log_valid), 64'd0);

        // back-pressure fill, then drain with concurrent refill
        do_reset();
        req_valid = '1;
        for (int k = 0; k < 8; k++) begin
            #1;
            check_val("fill_ready", 64'(req_ready), onehot(k % 4));
            next_cycle();
        end
        #1;
        check_val("full_ready", 64'(req_ready), 64'd0);
        check_val("full_count", 64'(log_count), 64'd8);
        check_val("full_head", log_cycle, 64'd0);
        next_cycle();
        log_ready = 1'b1;
        for (int j = 0; j < 8; j++) begin
            #1;
            check_val("drain_id", 64'(log_req_id), 64'(j % 4));
            check_val("drain_cycle", log_cycle, 64'(j));
            check_val("drain_ready", 64'(req_ready), onehot(j % 4));
            check_val("drain_count", 64'(log_count), 64'd8);
            next_cycle();
        end
        req_valid = '0;
        for (int j = 0; j < 8; j++) begin
            #1;
            check_val("refill_cycle", log_cycle, 64'(9 + j));
            check_val("refill_id", 64'(log_req_id), 64'(j % 4));
            check_val("refill_size", 64'(log_size), 64'(j % 4));
            check_val("refill_count", 64'(log_count), 64'(8 - j));
            next_cycle();
        end
        check_val("refill_empty", 64'(log_valid), 64'd0);

        // rr_ptr=2 with requesters 1 and 3; blocked grant must not rotate
        do_reset();
        req_valid = 4'b0011;
        repeat (8) next_cycle();
        req_valid = 4'b1010;
        #1;
        check_val("hold_ready0", 64'(req_ready), 64'd0);
        next_cycle();
        check_val("hold_ready1", 64'(req_ready), 64'd0);
        log_ready = 1'b1;
        #1;
        check_val("hold_grant3", 64'(req_ready), 64'b1000);
        check_val("hold_head_id", 64'(log_req_id), 64'd0);
        next_cycle();
        check_val("hold_grant1", 64'(req_ready), 64'b0010);
        check_val("hold_head2_id", 64'(log_req_id), 64'd1);
        check_val("hold_head2_cycle", log_cycle, 64'd1);

        // reset with 5 records buffered
        do_reset();
        req_valid = 4'b0100;
        repeat (5) next_cycle();
        req_valid = '0;
        #1;
        check_val("mid_count5", 64'(log_count), 64'd5);
        reset = 1'b1;
        #1;
        check_val("mid_rst_valid", 64'(log_valid), 64'd0);
        next_cycle();
        reset = 1'b0;
        #1;
        check_val("mid_after_count", 64'(log_count), 64'd0);
        check_val("mid_after_valid", 64'(log_valid), 64'd0);
        req_valid = 4'b0100;
        log_ready = 1'b1;
        #1;
        check_val("mid_push_ready", 64'(req_ready), 64'b0100);
        next_cycle();
        req_valid = '0;
        check_val("mid_stamp_valid", 64'(log_valid), 64'd1);
        check_val("mid_stamp_cycle", log_cycle, 64'd0);
        check_val("mid_stamp_id", 64'(log_req_id), 64'd2);
        check_val("mid_stamp_store", 64'(log_is_store), 64'd0);

        // cycle counter wrap
        do_reset();
        force dut.cycle_cnt = 64'hFFFF_FFFF_FFFF_FFFE;
        #1;
        release dut.cycle_cnt;
        req_valid = 4'b0100;
        repeat (3) next_cycle();
        req_valid = '0;
        #1;
        check_val("wrap_count", 64'(log_count), 64'd3);
        log_ready = 1'b1;
        for (int j = 0; j < 3; j++) begin
            #1;
            check_val("wrap_cycle", log_cycle, 64'hFFFF_FFFF_FFFF_FFFE + 64'(j));
            check_val("wrap_id", 64'(log_req_id), 64'd2);
            check_val("wrap_data", log_data, 64'hDA7A_0000_0000_0002);
            next_cycle();
        end
        check_val("wrap_empty", 64'(log_valid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
